// File: rtl/phase_pkg.sv
// Shared widths, scale constant, FSM state codes and the x3600 helper used by the
// phase measurement block.
package phase_pkg;

    localparam int CNT_W   = 28;
    localparam int PHASE_W = 12;
    localparam int PER_W   = CNT_W + 1;
    localparam int NUM_W   = CNT_W + 12;
    localparam int SCALE   = 3600;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_COUNT  = 2'd1;
    localparam state_t ST_DIVIDE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // 3600 = 2048 + 1024 + 512 + 16, so the product is four shifted adds.
    function automatic logic [NUM_W-1:0] scale_3600(input logic [CNT_W-1:0] delta);
        logic [NUM_W-1:0] d;
        d = NUM_W'(delta);
        return (d << 11) + (d << 10) + (d << 9) + (d << 4);
    endfunction

endpackage

// File: rtl/phase_difference_detection_if.sv
// Signal bundle between the phase detector and its environment: the two square
// waves, the upstream A high/low counts, and the measurement results.
interface phase_difference_detection_if;

    logic                          signal_a;
    logic                          signal_b;
    logic [phase_pkg::CNT_W-1:0]   high_level;
    logic [phase_pkg::CNT_W-1:0]   low_level;
    logic [phase_pkg::PHASE_W-1:0] phase;
    logic [phase_pkg::CNT_W-1:0]   delta_count;
    logic                          phase_valid;
    logic                          timeout;
    logic                          div_error;
    logic                          busy;

    modport master (
        output signal_a, signal_b, high_level, low_level,
        input  phase, delta_count, phase_valid, timeout, div_error, busy
    );

    modport slave (
        input  signal_a, signal_b, high_level, low_level,
        output phase, delta_count, phase_valid, timeout, div_error, busy
    );

endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The first step runs in
// the start cycle straight from the operand inputs; the quotient holds until restart.
module restoring_divider #(
    parameter int DIVIDEND_W = 40,
    parameter int DIVISOR_W  = 29,
    parameter int QUO_W      = DIVIDEND_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [QUO_W-1:0]      quotient_o
);

    localparam int ITER_W = $clog2(DIVIDEND_W + 1);

    logic                  running_q;
    logic [ITER_W-1:0]     iter_q;
    logic [DIVISOR_W-1:0]  rem_q, rem_d, div_q;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  src_rem, src_div;
    logic [DIVIDEND_W-1:0] src_quo;
    logic [DIVISOR_W:0]    trial, rem_wide;
    logic                  fits;

    // quo_q starts as the dividend and shifts left; quotient bits enter at the LSB.
    always_comb begin
        src_rem  = start_i ? '0         : rem_q;
        src_quo  = start_i ? dividend_i : quo_q;
        src_div  = start_i ? divisor_i  : div_q;
        trial    = {src_rem, src_quo[DIVIDEND_W-1]};
        fits     = trial >= {1'b0, src_div};
        rem_wide = fits ? trial - {1'b0, src_div} : trial;
        rem_d    = DIVISOR_W'(rem_wide);
        quo_d    = {src_quo[DIVIDEND_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            iter_q    <= '0;
        end else if (start_i) begin
            running_q <= 1'b1;
            iter_q    <= ITER_W'(1);
        end else if (running_q) begin
            iter_q <= iter_q + 1'b1;
            if (iter_q == ITER_W'(DIVIDEND_W - 1)) begin
                running_q <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are only read once start_i has loaded them.
    always_ff @(posedge clk) begin
        if (start_i || running_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
        if (start_i) begin
            div_q <= divisor_i;
        end
    end

    // done_o marks the cycle whose clock edge writes the final quotient bit.
    assign busy_o     = running_q;
    assign done_o     = running_q && (iter_q == ITER_W'(DIVIDEND_W - 1));
    assign quotient_o = quo_q[QUO_W-1:0];

endmodule

// File: rtl/phase_difference_detection.sv
// Measures the A-rise to B-rise lag in clock cycles and converts it to tenths of a
// degree using the upstream A period.
module phase_difference_detection
    import phase_pkg::*;
(
    input  logic                         clk_400M,
    input  logic                         rst,
    phase_difference_detection_if.slave  bus
);

    logic a_meta_q, a_sync_q, a_hist_q;
    logic b_meta_q, b_sync_q, b_hist_q;
    logic a_edge, b_edge;

    always_ff @(posedge clk_400M) begin
        if (rst) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            a_hist_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
            b_hist_q <= 1'b0;
        end else begin
            a_meta_q <= bus.signal_a;
            a_sync_q <= a_meta_q;
            a_hist_q <= a_sync_q;
            b_meta_q <= bus.signal_b;
            b_sync_q <= b_meta_q;
            b_hist_q <= b_sync_q;
        end
    end

    assign a_edge = a_sync_q & ~a_hist_q;
    assign b_edge = b_sync_q & ~b_hist_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   delta_q, delta_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   delta_count_q, delta_count_d;
    logic               phase_valid_q, phase_valid_d;
    logic               timeout_q, timeout_d;
    logic               div_error_q, div_error_d;

    logic [PER_W-1:0]   period;
    logic [NUM_W-1:0]   numerator;
    logic               div_entry, div_bad, div_start, div_busy, div_done;
    logic [PHASE_W-1:0] quotient;

    // The upstream counts each omit the cycle that ends them, hence the +2.
    assign period    = PER_W'(bus.high_level) + PER_W'(bus.low_level) + PER_W'(2);
    assign numerator = scale_3600(delta_q);
    assign div_entry = (state_q == ST_DIVIDE) && !div_busy;
    assign div_bad   = (period == '0) || ({1'b0, delta_q} >= period);
    assign div_start = div_entry && !div_bad;

    restoring_divider #(
        .DIVIDEND_W (NUM_W),
        .DIVISOR_W  (PER_W),
        .QUO_W      (PHASE_W)
    ) u_div (
        .clk        (clk_400M),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (numerator),
        .divisor_i  (period),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        delta_d       = delta_q;
        phase_d       = phase_q;
        delta_count_d = delta_count_q;
        phase_valid_d = 1'b0;
        timeout_d     = 1'b0;
        div_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_edge && b_edge) begin
                    delta_d = '0;
                    state_d = ST_DIVIDE;
                end else if (a_edge) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // B wins over a simultaneous A: the measurement in flight completes.
                if (b_edge) begin
                    delta_d = cnt_q;
                    state_d = ST_DIVIDE;
                end else if (a_edge) begin
                    timeout_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else if (&cnt_q) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DIVIDE: begin
                if (div_entry && div_bad) begin
                    div_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (div_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                phase_d       = quotient;
                delta_count_d = delta_q;
                phase_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_400M) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            delta_q       <= '0;
            phase_q       <= '0;
            delta_count_q <= '0;
            phase_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            div_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            delta_q       <= delta_d;
            phase_q       <= phase_d;
            delta_count_q <= delta_count_d;
            phase_valid_q <= phase_valid_d;
            timeout_q     <= timeout_d;
            div_error_q   <= div_error_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.delta_count = delta_count_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.div_error   = div_error_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
